uart_brg: RTL and testbench
===========================

// Module: uart_brg
// PURPOSE
// - 8N1 serial UART with built-in baud-rate generator; console link for the DL11-style tt_regs block.
// - Transmitter and receiver each talk to the register block through a 4-phase req/ack handshake.
// - Fully synchronous to clk. Baud timing comes from clock-enable ticks, not derived clocks, so there is no CDC.
// PARAMETERS
// - RX_DIV   default 326   clk cycles per rx tick (16x oversample; 50 MHz / (9600*16)).
// - One tx tick per 16 rx ticks; bit period = 16*RX_DIV clk cycles.
// PORTS
// - clk         in   1  system clock
// - reset       in   1  synchronous, active-high
// - ld_tx_req   in   1  request to load tx_data into transmitter
// - ld_tx_ack   out  1  load acknowledge
// - tx_data     in   8  byte to send
// - tx_enable   in   1  1 = frames may start
// - tx_out      out  1  serial line, idle high
// - tx_empty    out  1  1 = transmitter idle, no frame pending or in flight
// - uld_rx_req  in   1  request to unload received byte
// - uld_rx_ack  out  1  unload acknowledge
// - rx_data     out  8  last received byte
// - rx_enable   in   1  1 = receiver active
// - rx_in       in   1  serial line input, asynchronous
// - rx_empty    out  1  0 = unread byte held
// BEHAVIOUR
// - Reset values: tx_out=1, tx_empty=1, ld_tx_ack=0, rx_empty=1, uld_rx_ack=0, rx_data=0; all counters and state cleared.
// - Baud generator:
//   - rx_tick: 1-cycle pulse every RX_DIV clks.
//   - tx_tick: 1-cycle pulse on every 16th rx_tick.
//   - Both free-run out of reset.
// - TX load: if ld_tx_req=1 & ld_tx_ack=0 & tx_empty=1, then on that edge latch tx_data, tx_empty<=0, ld_tx_ack<=1.
//   - ld_tx_ack stays 1 while ld_tx_req=1; clears on the edge after ld_tx_req is sampled 0.
//   - A request while busy waits until tx_empty=1 and ack=0.
// - TX states IDLE->START->DATA(8)->STOP->IDLE:
//   - Frame begins at the first tx_tick after load with tx_enable=1.
//   - Each state advances on tx_tick.
//   - tx_out: START=0, DATA=bits LSB first, STOP=1.
//   - tx_empty<=1 at the tx_tick that ends STOP.
//   - tx_enable=0 only blocks start; an in-flight frame completes.
// - RX input: rx_in passes through a 2-flop synchronizer; all decisions use the synchronized value on rx_tick.
// - RX states IDLE->START->DATA->STOP:
//   - IDLE: 0 seen -> START.
//   - START: line still 0 after 8 ticks (mid-bit) -> DATA; else false start -> IDLE.
//   - DATA: sample every 16 ticks; 8 bits shifted LSB first.
//   - STOP: sample 16 ticks later. If 1: rx_data<=byte, rx_empty<=0. If 0 (framing error): discard, rx_data unchanged.
//   - Return to IDLE after STOP.
// - Overrun: a new valid byte with rx_empty=0 overwrites rx_data; no flag.
// - Unload: if uld_rx_req=1 & uld_rx_ack=0 & rx_empty=0, then uld_rx_ack<=1, rx_empty<=1.
//   - rx_data holds its value until the next valid byte.
//   - Ack clears on the edge after req is sampled 0.
// - Simultaneous unload and byte completion: byte completion wins (rx_empty=0, new rx_data); ack still asserts.
// - rx_enable=0: receiver forced to IDLE; stored byte unaffected.
// - Reset mid-frame aborts immediately to reset values.
// TESTING (RX_DIV=4, bit = 64 clks)
// - Reset -> tx_out=1, tx_empty=1, rx_empty=1, rx_data=0, both acks 0.
// - Load 0x72 via req/ack -> ack 1 clk after req; tx_empty=0 same edge; line 0,0,1,0,0,1,1,1,0,1 at 64 clk/bit; tx_empty=1 after stop.
// - Loop tx_out->rx_in, send 0x6B -> rx_empty=0, rx_data=0x6B; unload handshake -> rx_empty=1, rx_data stays 0x6B.
// - 20-clk low glitch on rx_in -> false start, rx_empty stays 1.
// - Frame with stop bit 0 -> discarded; rx_data unchanged, rx_empty=1.
// - Two bytes 0x30, 0x0D without unload -> rx_data=0x0D (overrun); req held high during tx -> no second load until ack cycle completes.

Source files
------------

// File: rtl/uart_brg.sv
// 8N1 UART with built-in baud-rate generator (16x oversampled receiver).
// The transmitter and receiver each hand bytes to the register block over a 4-phase req/ack handshake.
module uart_brg #(
  parameter int unsigned RX_DIV = 326
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ld_tx_req,
  output logic       ld_tx_ack,
  input  logic [7:0] tx_data,
  input  logic       tx_enable,
  output logic       tx_out,
  output logic       tx_empty,
  input  logic       uld_rx_req,
  output logic       uld_rx_ack,
  output logic [7:0] rx_data,
  input  logic       rx_enable,
  input  logic       rx_in,
  output logic       rx_empty
);

  localparam int unsigned DW = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic [DW-1:0] div_cnt;
  logic [3:0]    sub_cnt;
  logic          rx_tick;
  logic          tx_tick;

  assign rx_tick = (div_cnt == DW'(RX_DIV - 1));
  assign tx_tick = rx_tick && (sub_cnt == 4'd15);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      sub_cnt <= '0;
    end else if (rx_tick) begin
      div_cnt <= '0;
      sub_cnt <= sub_cnt + 4'd1;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // ---------------- transmitter ----------------
  tx_state_t  tx_state, tx_state_n;
  logic [7:0] tx_hold;
  logic [7:0] tx_shift;
  logic [2:0] tx_bit;

  always_ff @(posedge clk) begin
    if (reset) tx_state <= TX_IDLE;
    else       tx_state <= tx_state_n;
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_out     = 1'b1;
    case (tx_state)
      TX_IDLE:  if (tx_tick && !tx_empty && tx_enable) tx_state_n = TX_START;
      TX_START: begin
        tx_out = 1'b0;
        if (tx_tick) tx_state_n = TX_DATA;
      end
      TX_DATA: begin
        tx_out = tx_shift[0];
        if (tx_tick && tx_bit == 3'd7) tx_state_n = TX_STOP;
      end
      TX_STOP:  if (tx_tick) tx_state_n = TX_IDLE;
      default:  tx_state_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_empty  <= 1'b1;
      ld_tx_ack <= 1'b0;
      tx_hold   <= '0;
      tx_shift  <= '0;
      tx_bit    <= '0;
    end else begin
      if (ld_tx_req && !ld_tx_ack && tx_empty) begin
        tx_hold   <= tx_data;
        tx_empty  <= 1'b0;
        ld_tx_ack <= 1'b1;
      end else if (!ld_tx_req) begin
        ld_tx_ack <= 1'b0;
      end
      if (tx_state == TX_IDLE && tx_state_n == TX_START) begin
        tx_shift <= tx_hold;
        tx_bit   <= '0;
      end
      if (tx_state == TX_DATA && tx_tick) begin
        tx_shift <= {1'b0, tx_shift[7:1]};
        tx_bit   <= tx_bit + 3'd1;
      end
      // Load requires tx_empty=1, so this never races the load above.
      if (tx_state == TX_STOP && tx_tick) tx_empty <= 1'b1;
    end
  end

  // ---------------- receiver ----------------
  logic [1:0] rx_sync;
  logic       rx_s;
  rx_state_t  rx_state, rx_state_n;
  logic [3:0] rx_cnt, rx_cnt_n;
  logic [2:0] rx_bit, rx_bit_n;
  logic [7:0] rx_shift, rx_shift_n;
  logic       rx_commit;

  assign rx_s = rx_sync[1];

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_commit  = 1'b0;
    if (!rx_enable) begin
      rx_state_n = RX_IDLE;
    end else if (rx_tick) begin
      case (rx_state)
        RX_IDLE: if (!rx_s) begin
          rx_state_n = RX_START;
          rx_cnt_n   = '0;
        end
        RX_START: if (rx_cnt == 4'd7) begin
          if (!rx_s) begin
            rx_state_n = RX_DATA;
            rx_cnt_n   = '0;
            rx_bit_n   = '0;
          end else begin
            rx_state_n = RX_IDLE;
          end
        end else begin
          rx_cnt_n = rx_cnt + 4'd1;
        end
        RX_DATA: if (rx_cnt == 4'd15) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_s, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
          else                rx_bit_n   = rx_bit + 3'd1;
        end else begin
          rx_cnt_n = rx_cnt + 4'd1;
        end
        RX_STOP: if (rx_cnt == 4'd15) begin
          rx_state_n = RX_IDLE;
          rx_commit  = rx_s;
        end else begin
          rx_cnt_n = rx_cnt + 4'd1;
        end
        default: rx_state_n = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync    <= '1;
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_data    <= '0;
      rx_empty   <= 1'b1;
      uld_rx_ack <= 1'b0;
    end else begin
      rx_sync  <= {rx_sync[0], rx_in};
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
      if (uld_rx_req && !uld_rx_ack && !rx_empty) begin
        uld_rx_ack <= 1'b1;
        rx_empty   <= 1'b1;
      end else if (!uld_rx_req) begin
        uld_rx_ack <= 1'b0;
      end
      // Placed after the unload so a completing byte wins on a shared edge.
      if (rx_commit) begin
        rx_data  <= rx_shift;
        rx_empty <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_brg.sv
// Directed bench for uart_brg at RX_DIV=4 (64 clk per bit): line timing,
// loopback receive, unload handshake, false start, framing error and overrun.
module tb_uart_brg;
  localparam int unsigned RX_DIV = 4;
  localparam int unsigned BIT    = 64;

  logic       clk;
  logic       reset;
  logic       ld_tx_req;
  logic       ld_tx_ack;
  logic [7:0] tx_data;
  logic       tx_enable;
  logic       tx_out;
  logic       tx_empty;
  logic       uld_rx_req;
  logic       uld_rx_ack;
  logic [7:0] rx_data;
  logic       rx_enable;
  logic       rx_in;
  logic       rx_empty;
  logic       loop;
  logic       rx_drv;

  int total = 0;
  int bad   = 0;

  assign rx_in = loop ? tx_out : rx_drv;

  uart_brg #(.RX_DIV(RX_DIV)) dut (
    .clk(clk), .reset(reset),
    .ld_tx_req(ld_tx_req), .ld_tx_ack(ld_tx_ack), .tx_data(tx_data),
    .tx_enable(tx_enable), .tx_out(tx_out), .tx_empty(tx_empty),
    .uld_rx_req(uld_rx_req), .uld_rx_ack(uld_rx_ack), .rx_data(rx_data),
    .rx_enable(rx_enable), .rx_in(rx_in), .rx_empty(rx_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [7:0] b);
    tx_data   = b;
    ld_tx_req = 1'b1;
    tick(1);
    check("ld_ack", 32'(ld_tx_ack), 1);
    check("tx_busy", 32'(tx_empty), 0);
    ld_tx_req = 1'b0;
    tick(1);
    check("ld_ack_clr", 32'(ld_tx_ack), 0);
  endtask

  task automatic wait_tx_done();
    int n = 0;
    while (!tx_empty && n < 3000) begin
      tick(1);
      n++;
    end
    check("tx_done", 32'(tx_empty), 1);
  endtask

  task automatic wait_rx_full();
    int n = 0;
    while (rx_empty && n < 3000) begin
      tick(1);
      n++;
    end
    check("rx_full", 32'(rx_empty), 0);
  endtask

  task automatic unload();
    uld_rx_req = 1'b1;
    tick(1);
    check("uld_ack", 32'(uld_rx_ack), 1);
    check("uld_empty", 32'(rx_empty), 1);
    uld_rx_req = 1'b0;
    tick(1);
    check("uld_ack_clr", 32'(uld_rx_ack), 0);
  endtask

  task automatic send_raw(input logic [7:0] b, input logic stop);
    rx_drv = 1'b0;
    tick(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      tick(BIT);
    end
    rx_drv = stop;
    tick(BIT);
    rx_drv = 1'b1;
  endtask

  initial begin
    logic [9:0] line_exp;
    int n;
    int lows;

    reset = 1'b1; ld_tx_req = 1'b0; tx_data = '0; tx_enable = 1'b1;
    uld_rx_req = 1'b0; rx_enable = 1'b1; loop = 1'b0; rx_drv = 1'b1;
    tick(3);
    check("rst_tx_out", 32'(tx_out), 1);
    check("rst_tx_empty", 32'(tx_empty), 1);
    check("rst_ld_ack", 32'(ld_tx_ack), 0);
    check("rst_rx_empty", 32'(rx_empty), 1);
    check("rst_uld_ack", 32'(uld_rx_ack), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    reset = 1'b0;
    tick(5);

    // 0x72 line shape: start, data LSB first, stop
    line_exp = {1'b1, 8'h72, 1'b0};
    load_tx(8'h72);
    n = 0;
    while (tx_out && n < 200) begin
      tick(1);
      n++;
    end
    check("start_seen", 32'(tx_out), 0);
    tick(BIT / 2);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("line_bit%0d", i), 32'(tx_out), 32'(line_exp[i]));
      if (i < 9) tick(BIT);
    end
    check("stop_busy", 32'(tx_empty), 0);
    tick(40);
    check("stop_done", 32'(tx_empty), 1);
    tick(20);

    // loopback receive + unload
    loop = 1'b1;
    load_tx(8'h6B);
    wait_rx_full();
    check("loop_data", 32'(rx_data), 32'h6B);
    wait_tx_done();
    unload();
    check("data_kept", 32'(rx_data), 32'h6B);

    // short low glitch is a false start
    loop = 1'b0;
    rx_drv = 1'b0;
    tick(20);
    rx_drv = 1'b1;
    tick(400);
    check("glitch_empty", 32'(rx_empty), 1);

    // framing error discarded
    send_raw(8'h55, 1'b0);
    tick(300);
    check("frame_err_empty", 32'(rx_empty), 1);
    check("frame_err_data", 32'(rx_data), 32'h6B);

    // overrun; req held high blocks a second load
    loop = 1'b1;
    tx_data = 8'h30;
    ld_tx_req = 1'b1;
    tick(1);
    check("ov_ack", 32'(ld_tx_ack), 1);
    tx_data = 8'h0D;
    wait_tx_done();
    check("ov_first_data", 32'(rx_data), 32'h30);
    check("ov_first_full", 32'(rx_empty), 0);
    tick(10);
    check("ov_ack_held", 32'(ld_tx_ack), 1);
    check("ov_no_reload", 32'(tx_empty), 1);
    tx_enable = 1'b0;
    ld_tx_req = 1'b0;
    tick(1);
    check("ov_ack_clr", 32'(ld_tx_ack), 0);
    load_tx(8'h0D);
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (!tx_out) lows++;
    end
    check("tx_blocked", 32'(lows), 0);
    check("tx_pending", 32'(tx_empty), 0);
    tx_enable = 1'b1;
    wait_tx_done();
    tick(20);
    check("ov_data", 32'(rx_data), 32'h0D);
    check("ov_full", 32'(rx_empty), 0);
    unload();

    // bench-driven valid frame
    loop = 1'b0;
    send_raw(8'hA5, 1'b1);
    tick(100);
    check("raw_full", 32'(rx_empty), 0);
    check("raw_data", 32'(rx_data), 32'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
